// File: rtl/alu_sequencer.sv
// ============================================================================
//  Module      : alu_sequencer
//  Description : Multi-cycle accumulator sequencer driving an external 8-bit
//                ALU; fetches, decodes, executes, writes back, branches, halts.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] instr_addr,
    input  logic [7:0] instr_data,
    output logic [3:0] data_addr,
    input  logic [7:0] data_rd_data,
    output logic       data_wr_en,
    output logic [7:0] data_wr_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] ALU_sel,
    output logic [1:0] load_shift,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    input  logic       alu_zout,
    output logic [7:0] acc,
    output logic       cflag,
    output logic       zflag,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    localparam logic [3:0] c_OP_LD  = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_NOR = 4'h4;
    localparam logic [3:0] c_OP_SHL = 4'h5;
    localparam logic [3:0] c_OP_SHR = 4'h6;
    localparam logic [3:0] c_OP_CLR = 4'h7;
    localparam logic [3:0] c_OP_ST  = 4'h8;
    localparam logic [3:0] c_OP_JMP = 4'h9;
    localparam logic [3:0] c_OP_JZ  = 4'hA;
    localparam logic [3:0] c_OP_JC  = 4'hB;
    localparam logic [3:0] c_OP_LDI = 4'hC;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    state_t     r_state_q, w_state_d;
    logic [3:0] r_pc_q,    w_pc_d;
    logic [7:0] r_ir_q,    w_ir_d;
    logic [7:0] r_opnd_q,  w_opnd_d;
    logic [7:0] r_acc_q,   w_acc_d;
    logic       r_cflag_q, w_cflag_d;
    logic       r_zflag_q, w_zflag_d;
    logic       w_wr_en;

    logic [3:0] w_op;
    logic [3:0] w_field;
    assign w_op    = r_ir_q[7:4];
    assign w_field = r_ir_q[3:0];

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_ir_d    = r_ir_q;
        w_opnd_d  = r_opnd_q;
        w_acc_d   = r_acc_q;
        w_cflag_d = r_cflag_q;
        w_zflag_d = r_zflag_q;
        w_wr_en   = 1'b0;
        case (r_state_q)
            S_FETCH: begin
                w_ir_d    = instr_data;
                w_pc_d    = r_pc_q + 4'd1;
                w_state_d = S_DECODE;
            end
            S_DECODE: begin
                if (w_op inside {c_OP_LD, c_OP_ADD, c_OP_SUB, c_OP_NOR})
                    w_opnd_d = data_rd_data;
                else
                    w_opnd_d = {4'h0, w_field};
                w_state_d = S_FETCH;
                case (w_op)
                    c_OP_LD, c_OP_ADD, c_OP_SUB, c_OP_NOR,
                    c_OP_SHL, c_OP_SHR, c_OP_CLR, c_OP_LDI: w_state_d = S_EXECUTE;
                    c_OP_ST:  w_wr_en = 1'b1;
                    c_OP_JMP: w_pc_d  = w_field;
                    c_OP_JZ:  if (r_zflag_q) w_pc_d = w_field;
                    c_OP_JC:  if (r_cflag_q) w_pc_d = w_field;
                    c_OP_HLT: w_state_d = S_HALT;
                    default:  w_state_d = S_FETCH;
                endcase
            end
            S_EXECUTE: begin
                w_state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                w_acc_d   = alu_result;
                w_cflag_d = alu_cout;
                w_zflag_d = alu_zout;
                w_state_d = S_FETCH;
            end
            default: begin
                w_state_d = S_HALT;
            end
        endcase
    end

    // ALU controls are held over EXECUTE and WRITEBACK so the ALU has two cycles to settle.
    always_comb begin
        alu_a      = r_acc_q;
        alu_b      = r_opnd_q;
        ALU_sel    = 2'b00;
        load_shift = 2'b00;
        if (r_state_q == S_EXECUTE || r_state_q == S_WRITEBACK) begin
            case (w_op)
                c_OP_LD, c_OP_LDI: begin
                    alu_a      = r_opnd_q;
                    load_shift = 2'b10;
                end
                c_OP_ADD: ALU_sel    = 2'b10;
                c_OP_SUB: ALU_sel    = 2'b11;
                c_OP_NOR: ALU_sel    = 2'b01;
                c_OP_SHL: load_shift = 2'b01;
                c_OP_SHR: load_shift = 2'b11;
                default:  load_shift = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_FETCH;
            r_pc_q    <= RESET_PC;
            r_ir_q    <= 8'h00;
            r_opnd_q  <= 8'h00;
            r_acc_q   <= 8'h00;
            r_cflag_q <= 1'b0;
            r_zflag_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_ir_q    <= w_ir_d;
            r_opnd_q  <= w_opnd_d;
            r_acc_q   <= w_acc_d;
            r_cflag_q <= w_cflag_d;
            r_zflag_q <= w_zflag_d;
        end
    end

    assign instr_addr   = r_pc_q;
    assign data_addr    = r_ir_q[3:0];
    assign data_wr_en   = w_wr_en & ~rst;
    assign data_wr_data = r_acc_q;
    assign acc          = r_acc_q;
    assign cflag        = r_cflag_q;
    assign zflag        = r_zflag_q;
    assign halted       = (r_state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with ALU/memory models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] instr_addr, data_addr, instr_addr_w, data_addr_w;
    logic [7:0] instr_data, data_rd_data, data_wr_data, alu_a, alu_b, alu_result, acc;
    logic [7:0] instr_data_w, data_wr_data_w, alu_a_w, alu_b_w, alu_result_w, acc_w;
    logic [1:0] ALU_sel, load_shift, ALU_sel_w, load_shift_w;
    logic       data_wr_en, alu_cout, alu_zout, cflag, zflag, halted;
    logic       data_wr_en_w, alu_cout_w, alu_zout_w, cflag_w, zflag_w, halted_w;

    logic [7:0] prog [16];
    logic [7:0] dmem [16];
    logic [7:0] dmem_init [16];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [15:0] cyc;
    } store_t;
    store_t exp_q[$];

    always #5 clk = ~clk;

    // Reference ALU: returns {zero, carry, result}.
    function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [1:0] sel, input logic [1:0] ls);
        logic [8:0] r;
        case (sel)
            2'b10: r = {1'b0, a} + {1'b0, b};
            2'b11: r = {1'b0, a} - {1'b0, b};
            2'b01: r = {1'b0, ~(a | b)};
            default: begin
                case (ls)
                    2'b11:   r = {1'b0, 1'b0, a[7:1]};
                    2'b01:   r = {a, 1'b0};
                    2'b10:   r = {1'b0, a};
                    default: r = 9'h000;
                endcase
            end
        endcase
        return {(r[7:0] == 8'h00), r};
    endfunction

    assign instr_data   = prog[instr_addr];
    assign data_rd_data = dmem[data_addr];
    assign {alu_zout, alu_cout, alu_result} = alu_model(alu_a, alu_b, ALU_sel, load_shift);
    assign instr_data_w = prog[instr_addr_w];
    assign {alu_zout_w, alu_cout_w, alu_result_w} = alu_model(alu_a_w, alu_b_w, ALU_sel_w, load_shift_w);

    always @(posedge clk) begin
        if (rst) begin
            cyc <= 0;
            for (int i = 0; i < 16; i++) dmem[i] <= dmem_init[i];
        end else begin
            cyc <= cyc + 1;
            if (data_wr_en) dmem[data_addr] <= data_wr_data;
        end
    end

    alu_sequencer #(.RESET_PC(4'h0)) dut (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_data(instr_data),
        .data_addr(data_addr), .data_rd_data(data_rd_data), .data_wr_en(data_wr_en),
        .data_wr_data(data_wr_data), .alu_a(alu_a), .alu_b(alu_b), .ALU_sel(ALU_sel),
        .load_shift(load_shift), .alu_result(alu_result), .alu_cout(alu_cout),
        .alu_zout(alu_zout), .acc(acc), .cflag(cflag), .zflag(zflag), .halted(halted)
    );

    alu_sequencer #(.RESET_PC(4'hF)) dut_w (
        .clk(clk), .rst(rst), .instr_addr(instr_addr_w), .instr_data(instr_data_w),
        .data_addr(data_addr_w), .data_rd_data(8'h00), .data_wr_en(data_wr_en_w),
        .data_wr_data(data_wr_data_w), .alu_a(alu_a_w), .alu_b(alu_b_w), .ALU_sel(ALU_sel_w),
        .load_shift(load_shift_w), .alu_result(alu_result_w), .alu_cout(alu_cout_w),
        .alu_zout(alu_zout_w), .acc(acc_w), .cflag(cflag_w), .zflag(zflag_w), .halted(halted_w)
    );

    // Store scoreboard: every observed write strobe must match the next expected store.
    always @(negedge clk) begin
        if (data_wr_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL store_unexpected: got addr=%h data=%h cyc=%0d, required none",
                         data_addr, data_wr_data, cyc);
            end else begin
                store_t e;
                e = exp_q.pop_front();
                if ({data_addr, data_wr_data, cyc[15:0]} !== e) begin
                    n_err++;
                    $display("FAIL store_match: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                             data_addr, data_wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    // Holds rst high and loads a fresh program (all HLT) and zeroed data memory.
    task automatic begin_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog[i]      = 8'hF0;
            dmem_init[i] = 8'h00;
        end
    endtask

    task automatic end_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to(input int n);
        for (int i = 0; i < 500 && cyc < n; i++) @(negedge clk);
        n_cmp++;
        if (cyc != n) begin
            n_err++;
            $display("FAIL run_timeout: got cyc=%0d, required %0d", cyc, n);
        end
    endtask

    task automatic test_reset();
        begin_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (instr_addr !== 4'h0 || acc !== 8'h00) begin
            n_err++;
            $display("FAIL reset_pc_acc: got pc=%h acc=%h, required pc=0 acc=00", instr_addr, acc);
        end
        n_cmp++;
        if ({cflag, zflag, halted} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got c=%b z=%b h=%b, required 000", cflag, zflag, halted);
        end
        n_cmp++;
        if ({ALU_sel, load_shift, data_wr_en} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_ctrl: got sel=%b ls=%b we=%b, required 00 00 0",
                     ALU_sel, load_shift, data_wr_en);
        end
    endtask

    task automatic test_add_overflow();
        logic [3:0] pc_h;
        begin_reset();
        prog[0] = 8'hC5; prog[1] = 8'h23; prog[2] = 8'hF0;
        dmem_init[3] = 8'hFB;
        end_reset();
        run_to(9);
        n_cmp++;
        if (halted !== 1'b0) begin
            n_err++;
            $display("FAIL add_halt_early: got halted=%b at cyc 9, required 0", halted);
        end
        run_to(10);
        n_cmp++;
        if ({halted, acc, cflag, zflag} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL add_result: got h=%b acc=%h c=%b z=%b, required h=1 acc=00 c=1 z=1",
                     halted, acc, cflag, zflag);
        end
        pc_h = instr_addr;
        run_to(30);
        n_cmp++;
        if ({halted, acc, instr_addr} !== {1'b1, 8'h00, pc_h}) begin
            n_err++;
            $display("FAIL halt_hold: got h=%b acc=%h pc=%h, required h=1 acc=00 pc=%h",
                     halted, acc, instr_addr, pc_h);
        end
    endtask

    task automatic test_store();
        begin_reset();
        prog[0] = 8'hC9; prog[1] = 8'h87;
        exp_q.push_back('{addr: 4'h7, data: 8'h09, cyc: 16'd5});
        end_reset();
        run_to(10);
        n_cmp++;
        if (exp_q.size() != 0 || dmem[7] !== 8'h09) begin
            n_err++;
            $display("FAIL store_done: got pending=%0d mem7=%h, required 0 and 09", exp_q.size(), dmem[7]);
        end
    endtask

    task automatic branch_case(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                               input logic [7:0] m, input int n, input logic [3:0] exp_pc);
        begin_reset();
        prog[0] = p0; prog[1] = p1; prog[2] = p2;
        dmem_init[1] = 8'h01; dmem_init[2] = m;
        end_reset();
        run_to(n);
        n_cmp++;
        if (instr_addr !== exp_pc) begin
            n_err++;
            $display("FAIL branch %h_%h_%h: got pc=%h, required %h", p0, p1, p2, instr_addr, exp_pc);
        end
    endtask

    task automatic test_branches();
        branch_case(8'hC0, 8'hA5, 8'hF0, 8'h02, 6, 4'h5);
        branch_case(8'hC1, 8'hA5, 8'hF0, 8'h02, 6, 4'h2);
        begin_reset();
        prog[0] = 8'hC1; prog[1] = 8'h32; prog[2] = 8'hB9;
        dmem_init[2] = 8'h02;
        end_reset();
        run_to(8);
        n_cmp++;
        if ({acc, cflag, zflag} !== {8'hFF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: got acc=%h c=%b z=%b, required FF 1 0", acc, cflag, zflag);
        end
        run_to(10);
        n_cmp++;
        if (instr_addr !== 4'h9) begin
            n_err++;
            $display("FAIL jc_taken: got pc=%h, required 9", instr_addr);
        end
        branch_case(8'hC2, 8'h31, 8'hB9, 8'h02, 10, 4'h3);
    endtask

    task automatic shift_case(input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] exp_acc, input logic exp_z);
        begin_reset();
        prog[0] = p0; prog[1] = p1;
        end_reset();
        run_to(8);
        n_cmp++;
        if ({acc, zflag} !== {exp_acc, exp_z}) begin
            n_err++;
            $display("FAIL alu %h_%h: got acc=%h z=%b, required acc=%h z=%b",
                     p0, p1, acc, zflag, exp_acc, exp_z);
        end
    endtask

    task automatic test_shift_nor();
        shift_case(8'hC1, 8'h60, 8'h00, 1'b1);
        shift_case(8'hC8, 8'h50, 8'h10, 1'b0);
        shift_case(8'hC0, 8'h4A, 8'hFF, 1'b0);
        shift_case(8'hC3, 8'h1A, 8'h00, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        begin_reset();
        prog[0] = 8'hC5; prog[1] = 8'h23;
        dmem_init[3] = 8'hFB;
        end_reset();
        run_to(6);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({acc, cflag, zflag} !== {8'h05, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_exec_hold: got acc=%h c=%b z=%b, required 05 0 0", acc, cflag, zflag);
        end
        @(negedge clk);
        n_cmp++;
        if ({acc, cflag, zflag} !== {8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL rst_exec_clear: got acc=%h c=%b z=%b, required 00 0 0", acc, cflag, zflag);
        end
        begin_reset();
        prog[0] = 8'hC9; prog[1] = 8'h87;
        dmem_init[7] = 8'hAA;
        end_reset();
        run_to(5);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (data_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_store_gate: got data_wr_en=%b, required 0", data_wr_en);
        end
    endtask

    task automatic test_wrap();
        begin_reset();
        prog[15] = 8'h00; prog[0] = 8'hF0;
        end_reset();
        n_cmp++;
        if (instr_addr_w !== 4'hF) begin
            n_err++;
            $display("FAIL wrap_reset_pc: got pc=%h, required F", instr_addr_w);
        end
        run_to(1);
        n_cmp++;
        if (instr_addr_w !== 4'h0) begin
            n_err++;
            $display("FAIL wrap_next_pc: got pc=%h, required 0", instr_addr_w);
        end
        run_to(4);
        n_cmp++;
        if (halted_w !== 1'b1 || instr_addr_w !== 4'h1) begin
            n_err++;
            $display("FAIL wrap_halt: got h=%b pc=%h, required h=1 pc=1", halted_w, instr_addr_w);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            prog[i]      = 8'hF0;
            dmem_init[i] = 8'h00;
        end
        test_reset();
        test_add_overflow();
        test_store();
        test_branches();
        test_shift_nor();
        test_reset_mid_op();
        test_wrap();
        begin_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL store_pending: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
